// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and operand-sequencer state encodings
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_CAPTURE = 3'd4
    } seq_state_t;

endpackage

// File: rtl/load_edge_sync.sv
// rtl/load_edge_sync.sv - two-flop synchronizer plus rising-edge detector for the load button
module load_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], level};
            prev_q <= sync_q[1];
        end
    end

    // One pulse per low-to-high transition of the synchronized level.
    assign pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - loads A/B/opcode from a shared bus and captures the ALU result; ALU_SEQ_SYNC_EN selects button-style load input
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int N_BITS = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_BITS-1:0] i_data,
    input  logic              i_load,
    input  logic [N_BITS-1:0] i_res,
    output logic [N_BITS-1:0] o_A,
    output logic [N_BITS-1:0] o_B,
    output logic [N_BITS-1:0] o_OP,
    output logic [N_BITS-1:0] o_result,
    output logic              o_done,
    output logic              o_busy,
    output logic [2:0]        o_state
);

    seq_state_t state, state_next;
    logic       load_evt;
    logic       load_a, load_b, load_op, capture;

`ifdef ALU_SEQ_SYNC_EN
    load_edge_sync u_load_edge_sync (
        .clock (clock),
        .reset (reset),
        .level (i_load),
        .pulse (load_evt)
    );
`else
    assign load_evt = i_load;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    // Loads arriving in EXEC/CAPTURE simply fall through: no enable is raised there.
    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_WAIT_A: begin
                load_a = load_evt;
                if (load_evt) state_next = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                load_b = load_evt;
                if (load_evt) state_next = ST_WAIT_OP;
            end
            ST_WAIT_OP: begin
                load_op = load_evt;
                if (load_evt) state_next = ST_EXEC;
            end
            ST_EXEC: begin
                state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture    = 1'b1;
                state_next = ST_WAIT_A;
            end
            default: begin
                state_next = ST_WAIT_A;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_A      <= '0;
            o_B      <= '0;
            o_OP     <= '0;
            o_result <= '0;
            o_done   <= 1'b0;
        end else begin
            if (load_a)  o_A  <= i_data;
            if (load_b)  o_B  <= i_data;
            if (load_op) o_OP <= i_data;
            if (capture) o_result <= i_res;
            o_done <= capture;
        end
    end

    assign o_busy  = (state == ST_EXEC) || (state == ST_CAPTURE);
    assign o_state = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - directed and randomized bench for alu_operand_sequencer with an external ALU model
module tb_alu_operand_sequencer;

    localparam int N = 6;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] i_data = '0;
    logic         i_load = 1'b0;
    logic [N-1:0] i_res;
    logic [N-1:0] o_A, o_B, o_OP, o_result;
    logic         o_done, o_busy;
    logic [2:0]   o_state;

    int total = 0;
    int bad   = 0;

    alu_operand_sequencer #(.N_BITS(N)) dut (
        .clock    (clock),
        .reset    (reset),
        .i_data   (i_data),
        .i_load   (i_load),
        .i_res    (i_res),
        .o_A      (o_A),
        .o_B      (o_B),
        .o_OP     (o_OP),
        .o_result (o_result),
        .o_done   (o_done),
        .o_busy   (o_busy),
        .o_state  (o_state)
    );

    always #5 clock = ~clock;

    // Reference ALU arithmetic on unsigned 6-bit operands; undefined opcodes keep 'hold'.
    function automatic logic [5:0] ref_alu(input logic [5:0] a, input logic [5:0] b,
                                           input logic [5:0] op, input logic [5:0] hold);
        int ai, bi, r;
        ai = int'(a);
        bi = int'(b);
        case (op)
            6'b100000: r = ai + bi;
            6'b100010: r = ai - bi + 64;
            6'b100100: r = ai & bi;
            6'b100101: r = ai | bi;
            6'b100110: r = ai ^ bi;
            6'b000011: r = ai >> bi;
            6'b000010: r = ai >> bi;
            6'b100111: r = ~(ai | bi);
            default:   r = int'(hold);
        endcase
        return r[5:0];
    endfunction

    logic [5:0] alu_q;
    always @(posedge clock or posedge reset) begin
        if (reset) alu_q <= '0;
        else       alu_q <= ref_alu(o_A, o_B, o_OP, alu_q);
    end
    assign i_res = alu_q;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Returns #1 after the edge at which the load takes effect.
    task automatic do_load(input logic [5:0] d, input int gap);
`ifdef ALU_SEQ_SYNC_EN
        i_load = 1'b0;
        repeat (gap + 1) tick();
        i_data = d;
        i_load = 1'b1;
        repeat (3) tick();
        i_load = 1'b0;
`else
        i_load = 1'b0;
        repeat (gap) tick();
        i_data = d;
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
`endif
    endtask

    task automatic run_op(input logic [5:0] a, input logic [5:0] b, input logic [5:0] op,
                          input int gap);
        logic [5:0] exp;
        exp = ref_alu(a, b, op, 6'd0);
        do_load(a, gap);
        check("o_A", o_A, a);
        check("state_b", o_state, 3'd1);
        do_load(b, gap);
        check("o_B", o_B, b);
        check("state_op", o_state, 3'd2);
        do_load(op, gap);
        check("o_OP", o_OP, op);
        check("state_exec", o_state, 3'd3);
        check("busy_e0", o_busy, 1'b1);
        check("done_e0", o_done, 1'b0);
        tick();
        check("state_cap", o_state, 3'd4);
        check("busy_e1", o_busy, 1'b1);
        check("done_e1", o_done, 1'b0);
        tick();
        check("state_idle", o_state, 3'd0);
        check("busy_e2", o_busy, 1'b0);
        check("done_e2", o_done, 1'b1);
        check("result", o_result, exp);
        tick();
        check("done_e3", o_done, 1'b0);
        check("result_hold", o_result, exp);
    endtask

    initial begin
        #2;
        check("rst_state", o_state, 3'd0);
        check("rst_A", o_A, 6'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("rel_state", o_state, 3'd0);
        check("rel_busy", o_busy, 1'b0);
        check("rel_done", o_done, 1'b0);
        check("rel_result", o_result, 6'd0);
        check("rel_OP", o_OP, 6'd0);

        // Abort in WAIT_OP: reset acts between edges.
        do_load(6'd9, 0);
        do_load(6'd4, 0);
        check("pre_rst_state", o_state, 3'd2);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_state", o_state, 3'd0);
        check("mid_rst_A", o_A, 6'd0);
        check("mid_rst_B", o_B, 6'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        run_op(6'd5, 6'd3, 6'b100000, 0);
        run_op(6'd3, 6'd5, 6'b100010, 0);
        run_op(6'b101000, 6'd2, 6'b000011, 0);

`ifndef ALU_SEQ_SYNC_EN
        // Loads in EXEC and in CAPTURE are both dropped.
        do_load(6'd12, 0);
        do_load(6'd10, 0);
        do_load(6'b100100, 0);
        i_data = 6'd7;
        i_load = 1'b1;
        tick();
        check("drop_exec_state", o_state, 3'd4);
        tick();
        i_load = 1'b0;
        check("drop_cap_state", o_state, 3'd0);
        check("drop_A", o_A, 6'd12);
        check("drop_result", o_result, 6'd8);
        tick();
        check("drop_still_idle", o_state, 3'd0);
`endif

        for (int i = 0; i < 12; i++) begin
            logic [5:0] ops [8];
            ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                    6'b100110, 6'b000011, 6'b000010, 6'b100111};
            run_op(6'($urandom), 6'($urandom_range(0, 63)),
                   ops[$urandom_range(0, 7)], int'($urandom_range(0, 2)));
        end

`ifdef ALU_SEQ_SYNC_EN
        i_load = 1'b0;
        tick();
        i_data = 6'd21;
        i_load = 1'b1;
        tick();
        check("hold_e0", o_state, 3'd0);
        tick();
        check("hold_e1", o_state, 3'd0);
        tick();
        check("hold_e2", o_state, 3'd1);
        repeat (7) tick();
        check("hold_once", o_state, 3'd1);
        check("hold_A", o_A, 6'd21);
        i_load = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Front-end controller that drives the registered ALU from a single shared data bus. The operator presents A, B and the opcode on `i_data` one at a time, each confirmed by a load strobe. After the opcode is loaded, the block waits for the ALU's one-cycle registered latency, captures `i_res`, and holds it on `o_result` with a one-cycle `o_done` pulse. It sits between board switches/buttons and the ALU; it is the initiator side of the ALU's operand/result interface.

## Interface
- `N_BITS`, default 6: width of operands, opcode and result.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `i_data`  in  N_BITS  shared operand/opcode bus.
- `i_load`  in  1  load strobe; its form depends on Configuration.
- `i_res`  in  N_BITS  registered ALU result.
- `o_A`  out  N_BITS  operand A to the ALU.
- `o_B`  out  N_BITS  operand B to the ALU.
- `o_OP`  out  N_BITS  opcode to the ALU.
- `o_result`  out  N_BITS  last captured ALU result.
- `o_done`  out  1  one-cycle pulse when `o_result` updates.
- `o_busy`  out  1  high in EXEC and CAPTURE.
- `o_state`  out  3  current FSM state encoding, for LEDs/debug.

## Operation
- States and encodings: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, CAPTURE=4. Codes 5–7 are illegal and go to WAIT_A on the next edge.
- In WAIT_A, a load event sets `o_A` <= `i_data` and moves to WAIT_B.
- In WAIT_B, a load event sets `o_B` <= `i_data` and moves to WAIT_OP.
- In WAIT_OP, a load event sets `o_OP` <= `i_data` and moves to EXEC.
- EXEC lasts one cycle, during which the ALU registers its result. It then moves to CAPTURE unconditionally.
- CAPTURE lasts one cycle:
  - `o_result` <= `i_res` and `o_done` = 1.
  - Then returns to WAIT_A.
- Load events in EXEC or CAPTURE are dropped; they are not queued.
- `o_A`, `o_B` and `o_OP` hold their values until overwritten, so the ALU keeps recomputing the same result.
- `o_result` holds until the next CAPTURE.
- Opcode values are not checked. An unsupported opcode is passed through, and whatever `i_res` holds is captured.
- No arithmetic is performed in this block; all widths are N_BITS with no extension.

## Timing
- Reset values: all outputs are 0 and the state is WAIT_A.
  - `o_OP`=0 is not a defined ALU op, so the ALU holds its result.
- Reset asserted mid-sequence aborts the sequence immediately (asynchronously), and all outputs clear.
- Latency is measured from the edge E that loads `o_OP`:
  - EXEC is active during cycle E..E+1.
  - The ALU registers the result at E+1.
  - At E+2, `o_result` is valid and `o_done` is high for the cycle E+2..E+3.
- `o_busy` is high from E to E+2.
- A load event in the same cycle the FSM returns to WAIT_A (the CAPTURE cycle) is dropped.
- Back-to-back loads on consecutive cycles are each accepted in order (WAIT_A, then WAIT_B, then WAIT_OP).

## Configuration
- `ALU_SEQ_SYNC_EN` defined:
  - `i_load` is treated as an asynchronous level (button).
  - It passes through a 2-flop synchronizer, then rising-edge detection.
  - One load event per low-to-high transition; holding the button yields one event.
  - If `i_load` rises before edge 0, the event acts at edge 2.
- `ALU_SEQ_SYNC_EN` undefined:
  - `i_load` must be a synchronous single-cycle pulse and is used directly.
  - If it is high before edge 0, it acts at edge 0.
  - A level held high produces a load on every cycle.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode localparams (ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111);
  - the FSM state encodings.
  - The ALU and this block both import it.
- Sub-module `load_edge_sync`: synchronizer plus edge detector. It is instantiated only under `ALU_SEQ_SYNC_EN`.

## Test plan
- Reset, then release: all outputs are 0, `o_state`=0. Assert reset during WAIT_OP: outputs clear immediately and the state is WAIT_A.
- ADD: load `i_data`=5, then 3, then 100000. Two edges after the opcode load, `o_result`=8, with `o_done` pulsed exactly once and `o_busy` high for 2 cycles.
- SUB wrap: load A=3, B=5, OP=100010. `o_result`=62 (111110).
- Loads during EXEC/CAPTURE are ignored: pulse `i_load` with `i_data`=7 in EXEC. Next, `o_A` is unchanged and the state is WAIT_A.
- SRA: load A=101000, B=2, OP=000011. `o_result`=001010, since the ALU operands are unsigned.
- With `ALU_SEQ_SYNC_EN`: hold `i_load` high for 10 cycles in WAIT_A. Exactly one load occurs, and the state becomes WAIT_B 2 edges after the rise.
